cordic_rot_seq: RTL



---
 rtl/cordic_pkg.sv | 43 ++++
 rtl/cordic_rot_seq_lut.sv | 29 ++
 rtl/cordic_rot_seq.sv | 105 ++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared Q-format widths, constants, FSM states and pre-rotation helper
// used by the CORDIC rotation sequencer and its arctangent table.
package cordic_pkg;

    localparam int ANG_W    = 16;
    localparam int ANG_FRAC = 8;
    localparam int VEC_W    = 16;
    localparam int VEC_FRAC = 14;

    localparam logic signed [VEC_W-1:0] K_INIT  = 16'sd9949;
    localparam logic signed [ANG_W-1:0] ANG_P90 = 16'sh5A00;
    localparam logic signed [ANG_W-1:0] ANG_M90 = 16'shA600;

    typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

    typedef struct packed {
        logic signed [VEC_W-1:0] x;
        logic signed [VEC_W-1:0] y;
        logic signed [ANG_W-1:0] z;
    } cvec_t;

    // Folds angles beyond +/-90 deg into the CORDIC convergence range by
    // starting from a vector already rotated by +/-90 deg.
    function automatic cvec_t prerotate(input logic signed [ANG_W-1:0] ang,
                                        input logic signed [VEC_W-1:0] k);
        cvec_t v;
        if (ang > ANG_P90) begin
            v.x = '0;
            v.y = k;
            v.z = ang - ANG_P90;
        end else if (ang < ANG_M90) begin
            v.x = '0;
            v.y = -k;
            v.z = ang + ANG_P90;
        end else begin
            v.x = k;
            v.y = '0;
            v.z = ang;
        end
        return v;
    endfunction

endpackage

// File: rtl/cordic_rot_seq_lut.sv
// Arctangent table: atan(2^-sel) in signed Q7.8 degrees; entries 13..15 unused.
module lut
    import cordic_pkg::*;
(
    input  logic [3:0]              sel_i,
    output logic signed [ANG_W-1:0] atan_o
);

    always_comb begin
        atan_o = '0;
        case (sel_i)
            4'd0:    atan_o = 16'sd11520;
            4'd1:    atan_o = 16'sd6801;
            4'd2:    atan_o = 16'sd3593;
            4'd3:    atan_o = 16'sd1824;
            4'd4:    atan_o = 16'sd916;
            4'd5:    atan_o = 16'sd458;
            4'd6:    atan_o = 16'sd229;
            4'd7:    atan_o = 16'sd115;
            4'd8:    atan_o = 16'sd57;
            4'd9:    atan_o = 16'sd29;
            4'd10:   atan_o = 16'sd14;
            4'd11:   atan_o = 16'sd7;
            4'd12:   atan_o = 16'sd4;
            default: atan_o = '0;
        endcase
    end

endmodule

// File: rtl/cordic_rot_seq.sv
// Iterative CORDIC rotation: one Q7.8-degree angle in, Q1.14 cos/sin out,
// one micro-rotation per clock with valid/ready on both sides.
module cordic_rot_seq #(
    parameter int                 ITER   = 13,
    parameter logic signed [15:0] K_INIT = 16'sd9949
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_angle,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_cos,
    output logic signed [15:0] out_sin,
    output logic               busy
);
    import cordic_pkg::*;

    state_t                  state_q, state_d;
    logic [3:0]              idx_q, idx_d;
    cvec_t                   vec_q, vec_d, vec_rot;
    logic signed [VEC_W-1:0] cos_q, cos_d, sin_q, sin_d;
    logic signed [ANG_W-1:0] atan_w;

    lut u_lut (
        .sel_i  (idx_q),
        .atan_o (atan_w)
    );

    // Both coordinate updates read the pre-update x/y; shifts truncate.
    function automatic cvec_t micro_rot(input cvec_t v, input logic [3:0] sh,
                                        input logic signed [ANG_W-1:0] a);
        cvec_t                   r;
        logic signed [VEC_W-1:0] xs, ys;
        xs = $signed(v.x) >>> sh;
        ys = $signed(v.y) >>> sh;
        if (!v.z[ANG_W-1]) begin
            r.x = $signed(v.x) - ys;
            r.y = $signed(v.y) + xs;
            r.z = $signed(v.z) - a;
        end else begin
            r.x = $signed(v.x) + ys;
            r.y = $signed(v.y) - xs;
            r.z = $signed(v.z) + a;
        end
        return r;
    endfunction

    assign vec_rot = micro_rot(vec_q, idx_q, atan_w);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    vec_d   = prerotate(in_angle, K_INIT);
                    idx_d   = '0;
                    state_d = ROTATE;
                end
            end
            ROTATE: begin
                vec_d = vec_rot;
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'(ITER-1)) begin
                    cos_d   = vec_rot.x;
                    sin_d   = vec_rot.y;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_cos   = cos_q;
    assign out_sin   = sin_q;

endmodule
